// File: rtl/oled_spi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : oled_spi_arbiter
//  Description : Round-robin burst arbiter sharing one SPI-mode-0 OLED port
//                between a command requester and a data requester.
//  Revision    : 1.0 - initial release
// ============================================================================
module oled_spi_arbiter #(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       CmdReq,
    input  logic [7:0] CmdByte,
    input  logic       CmdLast,
    output logic       CmdAck,
    input  logic       DatReq,
    input  logic [7:0] DatByte,
    input  logic       DatLast,
    output logic       DatAck,
    output logic       Busy,
    output logic       SCLK,
    output logic       nCS,
    output logic       DnC,
    output logic       SDIN
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(CS_GAP - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT    = 3'd1,
        BYTE_END = 3'd2,
        STALL    = 3'd3,
        GAP      = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [2:0]         bit_q, bit_d;
    logic [6:0]         shreg_q, shreg_d;
    logic               last_q, last_d;
    logic               gnt_q, gnt_d;
    logic               ptr_q, ptr_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               sclk_q, sclk_d;
    logic               ncs_q, ncs_d;
    logic               dnc_q, dnc_d;
    logic               sdin_q, sdin_d;
    logic               cmd_ack_q, cmd_ack_d;
    logic               dat_ack_q, dat_ack_d;
    logic               busy_q, busy_d;

    logic               pick_dat;
    logic               sel_dat;
    logic               own_req;
    logic [7:0]         sel_byte;
    logic               sel_last;
    logic               load;

    // ptr_q=1 favours the data requester when both ask at once
    assign pick_dat = DatReq && (!CmdReq || ptr_q);
    assign sel_dat  = (state_q == IDLE) ? pick_dat : gnt_q;
    assign own_req  = gnt_q ? DatReq : CmdReq;
    assign sel_byte = sel_dat ? DatByte : CmdByte;
    assign sel_last = sel_dat ? DatLast : CmdLast;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        gap_d     = gap_q;
        sclk_d    = sclk_q;
        ncs_d     = ncs_q;
        dnc_d     = dnc_q;
        sdin_d    = sdin_q;
        cmd_ack_d = 1'b0;
        dat_ack_d = 1'b0;
        load      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (CmdReq || DatReq) begin
                    load  = 1'b1;
                    gnt_d = pick_dat;
                    dnc_d = pick_dat;
                    if (CmdReq && DatReq) begin
                        ptr_d = ~pick_dat;
                    end
                end
            end
            SHIFT: begin
                if (div_q == DIV_MAX) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // end of a high phase: next bit goes out with SCLK low
                        sclk_d = 1'b0;
                        if (bit_q == 3'd0) begin
                            sdin_d  = 1'b0;
                            state_d = BYTE_END;
                        end else begin
                            bit_d   = bit_q - 3'd1;
                            sdin_d  = shreg_q[6];
                            shreg_d = {shreg_q[5:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            BYTE_END: begin
                if (last_q) begin
                    state_d = GAP;
                    ncs_d   = 1'b1;
                    gap_d   = '0;
                end else if (own_req) begin
                    load = 1'b1;
                end else begin
                    state_d = STALL;
                end
            end
            STALL: begin
                if (own_req) begin
                    load = 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_MAX) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // bit7 leaves immediately on SDIN; the shifter keeps the rest
        if (load) begin
            state_d   = SHIFT;
            shreg_d   = sel_byte[6:0];
            sdin_d    = sel_byte[7];
            last_d    = sel_last;
            bit_d     = 3'd7;
            div_d     = '0;
            sclk_d    = 1'b0;
            ncs_d     = 1'b0;
            cmd_ack_d = ~sel_dat;
            dat_ack_d = sel_dat;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            last_q    <= 1'b0;
            gnt_q     <= 1'b0;
            ptr_q     <= 1'b0;
            gap_q     <= '0;
            sclk_q    <= 1'b0;
            ncs_q     <= 1'b1;
            dnc_q     <= 1'b0;
            sdin_q    <= 1'b0;
            cmd_ack_q <= 1'b0;
            dat_ack_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            gap_q     <= gap_d;
            sclk_q    <= sclk_d;
            ncs_q     <= ncs_d;
            dnc_q     <= dnc_d;
            sdin_q    <= sdin_d;
            cmd_ack_q <= cmd_ack_d;
            dat_ack_q <= dat_ack_d;
            busy_q    <= busy_d;
        end
    end

    assign CmdAck = cmd_ack_q;
    assign DatAck = dat_ack_q;
    assign Busy   = busy_q;
    assign SCLK   = sclk_q;
    assign nCS    = ncs_q;
    assign DnC    = dnc_q;
    assign SDIN   = sdin_q;

endmodule
`default_nettype wire

// File: doc/oled_spi_arbiter.md
Name: oled_spi_arbiter

Overview:
Shares the single OLED SPI port (SCLK, nCS, DnC, SDIN) between two requesters inside comp_core: the command sequencer (init, addressing) and the pixel/data writer. It arbitrates round-robin at burst granularity, serialises bytes MSB-first in SPI mode 0 and frames each burst with one nCS low period. DnC is driven from the requester identity. It sits between the display logic and the SCLK/nCS/DnC/SDIN output pads.

Parameters:
CLK_DIV, 2, Clock cycles per SCLK half-period; legal range >=1.
CS_GAP, 2, Clock cycles nCS is held high after a burst before the next grant; legal range >=1.

Ports:
Clock  input  1  system clock; all logic rising-edge.
Reset  input  1  synchronous, active-high reset.
CmdReq  input  1  command requester wants to send CmdByte.
CmdByte  input  8  command byte; stable while CmdReq=1 and no CmdAck.
CmdLast  input  1  CmdByte is the last byte of the burst.
CmdAck  output  1  one-cycle pulse: CmdByte latched.
DatReq  input  1  data requester wants to send DatByte.
DatByte  input  8  data byte; same stability rule as CmdByte.
DatLast  input  1  DatByte is the last byte of the burst.
DatAck  output  1  one-cycle pulse: DatByte latched.
Busy  output  1  high whenever the FSM is not IDLE.
SCLK  output  1  SPI clock; idles low.
nCS  output  1  SPI chip select, active low.
DnC  output  1  0 = command (Cmd grant), 1 = data (Dat grant).
SDIN  output  1  serial data, MSB first.

Behaviour:
- All outputs are registered. Reset values: nCS=1, SCLK=0, SDIN=0, DnC=0, CmdAck=0, DatAck=0, Busy=0. The round-robin pointer resets to favour Cmd.
- FSM states: IDLE, SHIFT, BYTE_END, STALL, GAP.
- IDLE:
  - Sample requests. If only one requester is active, grant it.
  - If both are active, grant the one favoured by the pointer. The pointer then flips to favour the other requester.
  - On grant at edge t0: latch the byte into the shift register and the Last flag into last_r.
  - During cycle t0+1: Ack=1 for that requester, nCS=0, DnC set (0 for Cmd, 1 for Dat), SDIN = bit7. Go to SHIFT.
- SHIFT:
  - Each bit is a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles.
  - SDIN changes only at the start of a low phase, so the slave samples on the SCLK rising edge.
  - A byte occupies 16*CLK_DIV cycles. Bit counter is 3 bits; the divider counter is sized for CLK_DIV.
  - After the bit0 high phase, SCLK returns low and the FSM enters BYTE_END.
- BYTE_END (1 cycle; nCS=0, SCLK=0):
  - last_r=1: go to GAP.
  - Otherwise, granted Req=1: latch the next byte, pulse Ack in the following cycle, go to SHIFT.
  - Otherwise (Req=0): go to STALL.
- STALL: nCS stays 0, SCLK stays 0, DnC holds, and the grant holds. The other requester is ignored. When the granted Req=1, latch, Ack and go to SHIFT exactly as in BYTE_END.
- GAP: nCS=1, SCLK=0 for CS_GAP cycles, then IDLE. Requests are not sampled in GAP.
- Ack is never asserted for a byte that is not transmitted. At most one Ack is high in any cycle.
- Reset asserted in any state forces reset values at the next edge. A partial byte is abandoned without an extra Ack. The next transfer starts with a fresh nCS falling edge.
- DnC changes only while nCS=1 or in the grant cycle; it never changes mid-burst.

Test Plan:
1. CLK_DIV=2, CS_GAP=2; CmdReq=1, CmdByte=0xAE, CmdLast=1 sampled at t0.
   - Cycle t0+1: CmdAck=1 for one cycle.
   - nCS=0 during t0+1..t0+33.
   - 8 SCLK rising edges at t0+3+4k.
   - SDIN at the rising edges = 1,0,1,0,1,1,1,0; DnC=0.
   - nCS=1 from t0+34; Busy=0 at t0+36.
2. Reset then CmdReq=DatReq=1 (single bytes 0x11 and 0x22).
   - Cmd served first (DnC=0), then Dat (DnC=1) after the GAP.
   - Both requesting again: Dat wins, since the pointer favours Dat after Cmd was last granted.
3. Dat burst 0x01, 0x02, 0xFF (last only on 0xFF).
   - Three DatAck pulses.
   - nCS low continuously across 24 rising edges; DnC=1 throughout.
   - Exactly one idle SCLK-low BYTE_END cycle between bytes.
4. Cmd burst, first byte CmdLast=0, then CmdReq dropped for 10 cycles while DatReq=1.
   - nCS stays 0, SCLK stays 0, no DatAck.
   - On CmdReq=1, the next byte is sent under the same nCS.
5. Reset pulsed after the 3rd SCLK rising edge of byte 0x5A.
   - Next cycle: nCS=1, SCLK=0, SDIN=0, Busy=0, no Ack.
   - A following CmdReq with 0xA5 is transmitted fully with correct bits.
6. CmdReq asserted during GAP.
   - Not granted until IDLE.
   - CmdAck arrives exactly 1 cycle after the first IDLE sample.
